// File: rtl/mac_lookup_arbiter_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces for mac_lookup_arbiter.
//
// mac_req_if : requester side (one lane per requester, fields flattened)
//    req_en        requester -> arbiter  one-cycle lookup request pulse
//    req_ready     arbiter -> requester  slot empty
//    req_src_vlan  requester -> arbiter  12 bits per requester
//    req_src_mac   requester -> arbiter  48 bits per requester
//    req_src_port  requester -> arbiter  6 bits per requester
//    req_dst_mac   requester -> arbiter  48 bits per requester
//    req_done      arbiter -> requester  one-cycle result pulse
//    req_hit       arbiter -> requester  result hit, valid with req_done
//    req_dst_port  arbiter -> requester  6 bits per requester, valid with req_done
//    modport master = requester side, modport slave = arbiter side
//
// mac_tbl_if : MAC table lookup port
//    tbl_lookup_en       arbiter -> table  one-cycle lookup pulse
//    tbl_src_vlan/mac/port, tbl_dst_mac   arbiter -> table  held until result
//    tbl_lookup_done     table -> arbiter  result pulse
//    tbl_lookup_hit      table -> arbiter  hit
//    tbl_lookup_dst_port table -> arbiter  destination port
//    modport master = arbiter side, modport slave = table side
// ---------------------------------------------------------------------------
interface mac_req_if #(
   parameter int unsigned NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req_en;
   logic [NUM_REQ-1:0]    req_ready;
   logic [12*NUM_REQ-1:0] req_src_vlan;
   logic [48*NUM_REQ-1:0] req_src_mac;
   logic [6*NUM_REQ-1:0]  req_src_port;
   logic [48*NUM_REQ-1:0] req_dst_mac;
   logic [NUM_REQ-1:0]    req_done;
   logic [NUM_REQ-1:0]    req_hit;
   logic [6*NUM_REQ-1:0]  req_dst_port;

   modport master (
      output req_en, req_src_vlan, req_src_mac, req_src_port, req_dst_mac,
      input  req_ready, req_done, req_hit, req_dst_port
   );

   modport slave (
      input  req_en, req_src_vlan, req_src_mac, req_src_port, req_dst_mac,
      output req_ready, req_done, req_hit, req_dst_port
   );
endinterface

interface mac_tbl_if;
   logic        tbl_lookup_en;
   logic [11:0] tbl_src_vlan;
   logic [47:0] tbl_src_mac;
   logic [5:0]  tbl_src_port;
   logic [47:0] tbl_dst_mac;
   logic        tbl_lookup_done;
   logic        tbl_lookup_hit;
   logic [5:0]  tbl_lookup_dst_port;

   modport master (
      output tbl_lookup_en, tbl_src_vlan, tbl_src_mac, tbl_src_port, tbl_dst_mac,
      input  tbl_lookup_done, tbl_lookup_hit, tbl_lookup_dst_port
   );

   modport slave (
      input  tbl_lookup_en, tbl_src_vlan, tbl_src_mac, tbl_src_port, tbl_dst_mac,
      output tbl_lookup_done, tbl_lookup_hit, tbl_lookup_dst_port
   );
endinterface

// File: rtl/mac_lookup_arbiter.sv
// ---------------------------------------------------------------------------
// mac_lookup_arbiter
// Round-robin arbiter sharing the single MAC table lookup port among NUM_REQ
// requesters. Each requester owns a one-deep holding slot; one lookup is in
// flight at a time and its result is returned to the owning requester. A
// lookup that gets no table response within TIMEOUT_CYCLES completes as a
// forced miss.
//
// Ports:
//    clk            fabric clock
//    rst            synchronous active-high reset
//    req            mac_req_if.slave   requester request/result bus
//    tbl            mac_tbl_if.master  MAC table lookup port
//    stat_lookups   completed lookups incl. timeouts, wraps
//    stat_drops     req_en pulses that hit a full slot, saturating
//    stat_timeouts  forced-miss completions, saturating
// ---------------------------------------------------------------------------
module mac_lookup_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   mac_req_if.slave    req,
   mac_tbl_if.master   tbl,
   output logic [31:0] stat_lookups,
   output logic [15:0] stat_drops,
   output logic [15:0] stat_timeouts
);

   localparam int unsigned PW = $clog2(NUM_REQ);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   // holding slots
   logic [NUM_REQ-1:0] r_valid;
   logic [11:0]        r_vlan  [NUM_REQ];
   logic [47:0]        r_smac  [NUM_REQ];
   logic [5:0]         r_sport [NUM_REQ];
   logic [47:0]        r_dmac  [NUM_REQ];

   // arbitration / lookup state
   logic [0:0]    r_state;
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] r_owner;
   logic [7:0]    r_timer;

   logic          r_lookup_en;
   logic [11:0]   r_tbl_vlan;
   logic [47:0]   r_tbl_smac;
   logic [5:0]    r_tbl_sport;
   logic [47:0]   r_tbl_dmac;

   logic [NUM_REQ-1:0]   r_done;
   logic [NUM_REQ-1:0]   r_hit;
   logic [6*NUM_REQ-1:0] r_dst_port;

   logic [31:0] r_lookups;
   logic [15:0] r_drops;
   logic [15:0] r_timeouts;

   logic               w_any;
   logic [PW-1:0]      w_win;
   logic               w_tmo;
   logic               w_complete;
   logic [NUM_REQ-1:0] w_clear;
   logic [NUM_REQ-1:0] w_drop;
   logic [16:0]        w_drop_sum;

   // index k positions after base, modulo NUM_REQ
   function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int unsigned k);
      int unsigned s;
      s = 32'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return PW'(s);
   endfunction

   // first valid slot searching from r_ptr upwards with wrap
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!w_any && r_valid[rr_idx(r_ptr, k)]) begin
            w_any = 1'b1;
            w_win = rr_idx(r_ptr, k);
         end
      end
   end

   assign w_tmo      = (r_timer == 8'(TIMEOUT_CYCLES));
   assign w_complete = (r_state == ST_WAIT) && (tbl.tbl_lookup_done || w_tmo);

   // a slot being released this cycle may be refilled in the same cycle, so
   // a request against it is a capture rather than a drop
   always_comb begin
      w_clear    = '0;
      w_drop     = '0;
      w_drop_sum = {1'b0, r_drops};
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_clear[i] = w_complete && (r_owner == PW'(i));
         w_drop[i]  = req.req_en[i] && r_valid[i] && !w_clear[i];
         w_drop_sum = w_drop_sum + 17'(w_drop[i]);
      end
   end

   // slot capture / release
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req.req_en[i] && (!r_valid[i] || w_clear[i])) begin
               r_valid[i] <= 1'b1;
               r_vlan[i]  <= req.req_src_vlan[i*12 +: 12];
               r_smac[i]  <= req.req_src_mac[i*48 +: 48];
               r_sport[i] <= req.req_src_port[i*6 +: 6];
               r_dmac[i]  <= req.req_dst_mac[i*48 +: 48];
            end else if (w_clear[i]) begin
               r_valid[i] <= 1'b0;
            end
         end
      end
   end

   // lookup FSM, results and statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_owner     <= '0;
         r_timer     <= '0;
         r_lookup_en <= 1'b0;
         r_tbl_vlan  <= '0;
         r_tbl_smac  <= '0;
         r_tbl_sport <= '0;
         r_tbl_dmac  <= '0;
         r_done      <= '0;
         r_hit       <= '0;
         r_dst_port  <= '0;
         r_lookups   <= '0;
         r_drops     <= '0;
         r_timeouts  <= '0;
      end else begin
         r_lookup_en <= 1'b0;
         r_done      <= '0;
         r_drops     <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_owner     <= w_win;
                  r_tbl_vlan  <= r_vlan[w_win];
                  r_tbl_smac  <= r_smac[w_win];
                  r_tbl_sport <= r_sport[w_win];
                  r_tbl_dmac  <= r_dmac[w_win];
                  r_lookup_en <= 1'b1;
                  r_timer     <= '0;
                  r_ptr       <= (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + PW'(1);
                  r_state     <= ST_WAIT;
               end
            end
            default: begin
               r_timer <= r_timer + 8'd1;
               if (w_complete) begin
                  // a table response in the timeout cycle still counts as a real result
                  r_done[r_owner]                  <= 1'b1;
                  r_hit[r_owner]                   <= tbl.tbl_lookup_done & tbl.tbl_lookup_hit;
                  r_dst_port[32'(r_owner)*6 +: 6]  <= tbl.tbl_lookup_done ? tbl.tbl_lookup_dst_port : 6'd0;
                  r_lookups                        <= r_lookups + 32'd1;
                  if (!tbl.tbl_lookup_done && (r_timeouts != 16'hFFFF)) begin
                     r_timeouts <= r_timeouts + 16'd1;
                  end
                  r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign req.req_ready    = ~r_valid;
   assign req.req_done     = r_done;
   assign req.req_hit      = r_hit;
   assign req.req_dst_port = r_dst_port;

   assign tbl.tbl_lookup_en = r_lookup_en;
   assign tbl.tbl_src_vlan  = r_tbl_vlan;
   assign tbl.tbl_src_mac   = r_tbl_smac;
   assign tbl.tbl_src_port  = r_tbl_sport;
   assign tbl.tbl_dst_mac   = r_tbl_dmac;

   assign stat_lookups  = r_lookups;
   assign stat_drops    = r_drops;
   assign stat_timeouts = r_timeouts;

endmodule

// File: tb/tb_mac_lookup_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mac_lookup_arbiter
// Directed bench for mac_lookup_arbiter. Stimulus pushes expected lookups
// and expected results into queues; a monitor pops and compares whenever the
// DUT pulses tbl_lookup_en or req_done. A small table responder answers each
// lookup after resp_delay cycles with hit = dst_mac[0], port = dst_mac[13:8].
// ---------------------------------------------------------------------------
module tb_mac_lookup_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned TMO  = 8;

   typedef struct {
      logic [5:0]  sport;
      logic [11:0] vlan;
      logic [47:0] smac;
      logic [47:0] dmac;
   } iss_t;

   typedef struct {
      int         req;
      logic       hit;
      logic [5:0] port;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] stat_lookups;
   logic [15:0] stat_drops;
   logic [15:0] stat_timeouts;

   mac_req_if #(.NUM_REQ(NREQ)) req_bus ();
   mac_tbl_if                   tbl_bus ();

   mac_lookup_arbiter #(
      .NUM_REQ        (NREQ),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req_bus),
      .tbl           (tbl_bus),
      .stat_lookups  (stat_lookups),
      .stat_drops    (stat_drops),
      .stat_timeouts (stat_timeouts)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   iss_t iss_q[$];
   res_t sb_q[$];
   int   last_issue_cyc = 0;
   int   prev_issue_cyc = 0;
   int   last_done_cyc  = 0;
   logic tbl_respond    = 1'b1;
   int   resp_delay     = 1;
   int   stray_cyc      = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // table responder
   initial begin : responder
      int         cnt;
      logic       pend_hit;
      logic [5:0] pend_port;
      cnt       = 0;
      pend_hit  = 1'b0;
      pend_port = '0;
      tbl_bus.tbl_lookup_done     = 1'b0;
      tbl_bus.tbl_lookup_hit      = 1'b0;
      tbl_bus.tbl_lookup_dst_port = '0;
      forever begin
         @(posedge clk);
         #1;
         tbl_bus.tbl_lookup_done = 1'b0;
         if (cyc == stray_cyc) begin
            tbl_bus.tbl_lookup_done     = 1'b1;
            tbl_bus.tbl_lookup_hit      = 1'b1;
            tbl_bus.tbl_lookup_dst_port = 6'h07;
         end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               tbl_bus.tbl_lookup_done     = 1'b1;
               tbl_bus.tbl_lookup_hit      = pend_hit;
               tbl_bus.tbl_lookup_dst_port = pend_port;
            end
         end
         if (tbl_bus.tbl_lookup_en === 1'b1 && tbl_respond) begin
            cnt       = resp_delay;
            pend_hit  = tbl_bus.tbl_dst_mac[0];
            pend_port = tbl_bus.tbl_dst_mac[13:8];
         end
      end
   end

   // monitor
   initial begin : monitor
      iss_t ie;
      res_t re;
      forever begin
         @(negedge clk);
         if (tbl_bus.tbl_lookup_en === 1'b1) begin
            prev_issue_cyc = last_issue_cyc;
            last_issue_cyc = cyc;
            if (iss_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_issue actual src_port=0x%0h required=no lookup (cycle %0d)",
                        tbl_bus.tbl_src_port, cyc);
            end else begin
               ie = iss_q.pop_front();
               check("issue_src_port", tbl_bus.tbl_src_port, ie.sport);
               check("issue_src_vlan", tbl_bus.tbl_src_vlan, ie.vlan);
               check("issue_src_mac",  tbl_bus.tbl_src_mac,  ie.smac);
               check("issue_dst_mac",  tbl_bus.tbl_dst_mac,  ie.dmac);
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_bus.req_done[i] === 1'b1) begin
               last_done_cyc = cyc;
               if (sb_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_done actual req=%0d required=no result (cycle %0d)", i, cyc);
               end else begin
                  re = sb_q.pop_front();
                  check("done_req",      i, re.req);
                  check("done_hit",      req_bus.req_hit[i], re.hit);
                  check("done_port",     req_bus.req_dst_port[i*6 +: 6], re.port);
                  check("ready_in_done", req_bus.req_ready[i], 1);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=time limit required=finish");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input int i, input logic [11:0] vlan, input logic [47:0] smac,
                       input logic [5:0] sport, input logic [47:0] dmac);
      req_bus.req_src_vlan[i*12 +: 12] = vlan;
      req_bus.req_src_mac[i*48 +: 48]  = smac;
      req_bus.req_src_port[i*6 +: 6]   = sport;
      req_bus.req_dst_mac[i*48 +: 48]  = dmac;
   endtask

   task automatic pulse(input logic [NREQ-1:0] m);
      req_bus.req_en = m;
      @(posedge clk);
      #1;
      req_bus.req_en = '0;
   endtask

   task automatic exp_issue(input logic [5:0] sport, input logic [11:0] vlan,
                            input logic [47:0] smac, input logic [47:0] dmac);
      iss_t e;
      e.sport = sport;
      e.vlan  = vlan;
      e.smac  = smac;
      e.dmac  = dmac;
      iss_q.push_back(e);
   endtask

   task automatic exp_done(input int r, input logic h, input logic [5:0] p);
      res_t e;
      e.req  = r;
      e.hit  = h;
      e.port = p;
      sb_q.push_back(e);
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || iss_q.size() != 0) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, sb_q.size() + iss_q.size(), 0);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      idle(cycles);
      rst = 1'b0;
      check("rst_ready",      req_bus.req_ready, 4'hF);
      check("rst_done",       req_bus.req_done, 0);
      check("rst_hit",        req_bus.req_hit, 0);
      check("rst_dst_port",   req_bus.req_dst_port, 0);
      check("rst_lookup_en",  tbl_bus.tbl_lookup_en, 0);
      check("rst_tbl_vlan",   tbl_bus.tbl_src_vlan, 0);
      check("rst_tbl_dmac",   tbl_bus.tbl_dst_mac, 0);
      check("rst_lookups",    stat_lookups, 0);
      check("rst_drops",      stat_drops, 0);
      check("rst_timeouts",   stat_timeouts, 0);
   endtask

   initial begin
      int n;
      req_bus.req_en       = '0;
      req_bus.req_src_vlan = '0;
      req_bus.req_src_mac  = '0;
      req_bus.req_src_port = '0;
      req_bus.req_dst_mac  = '0;
      do_reset(3);

      // single request, table answers 2 cycles after the lookup
      resp_delay = 2;
      load(0, 12'h00A, 48'h0200_0000_0000, 6'h20, 48'h0000_0000_0501);
      exp_issue(6'h20, 12'h00A, 48'h0200_0000_0000, 48'h0000_0000_0501);
      exp_done(0, 1'b1, 6'h05);
      n = cyc;
      pulse(4'b0001);
      drain("single_drain", 30);
      check("single_issue_latency", last_issue_cyc - n, 2);
      check("single_done_latency",  last_done_cyc - n, 5);
      check("single_lookups", stat_lookups, 1);

      // fairness from ptr 0
      do_reset(2);
      resp_delay = 1;
      load(0, 12'h100, 48'h0200_0000_0010, 6'h20, 48'h0000_0000_1000);
      load(1, 12'h101, 48'h0200_0000_0011, 6'h21, 48'h0000_0000_1101);
      load(2, 12'h102, 48'h0200_0000_0012, 6'h22, 48'h0000_0000_1200);
      load(3, 12'h103, 48'h0200_0000_0013, 6'h23, 48'h0000_0000_1301);
      exp_issue(6'h20, 12'h100, 48'h0200_0000_0010, 48'h0000_0000_1000);
      exp_issue(6'h21, 12'h101, 48'h0200_0000_0011, 48'h0000_0000_1101);
      exp_issue(6'h22, 12'h102, 48'h0200_0000_0012, 48'h0000_0000_1200);
      exp_issue(6'h23, 12'h103, 48'h0200_0000_0013, 48'h0000_0000_1301);
      exp_done(0, 1'b0, 6'h10);
      exp_done(1, 1'b1, 6'h11);
      exp_done(2, 1'b0, 6'h12);
      exp_done(3, 1'b1, 6'h13);
      pulse(4'b1111);
      drain("fair_drain", 60);
      check("fair_issue_spacing", last_issue_cyc - prev_issue_cyc, 3);
      check("fair_lookups", stat_lookups, 4);

      // requesters 3 and 0 together with ptr back at 0
      load(3, 12'h203, 48'h0200_0000_0023, 6'h23, 48'h0000_0000_2A01);
      load(0, 12'h200, 48'h0200_0000_0020, 6'h20, 48'h0000_0000_3F00);
      exp_issue(6'h20, 12'h200, 48'h0200_0000_0020, 48'h0000_0000_3F00);
      exp_issue(6'h23, 12'h203, 48'h0200_0000_0023, 48'h0000_0000_2A01);
      exp_done(0, 1'b0, 6'h3F);
      exp_done(3, 1'b1, 6'h2A);
      pulse(4'b1001);
      drain("pair_drain", 40);
      check("pair_lookups", stat_lookups, 6);

      // drop: second request while slot 1 is still pending
      resp_delay = 5;
      load(1, 12'h301, 48'h0200_0000_0031, 6'h21, 48'h0000_0000_0701);
      exp_issue(6'h21, 12'h301, 48'h0200_0000_0031, 48'h0000_0000_0701);
      exp_done(1, 1'b1, 6'h07);
      pulse(4'b0010);
      load(1, 12'h3FF, 48'h0200_0000_00FF, 6'h21, 48'h0000_0000_3E00);
      pulse(4'b0010);
      drain("drop_drain", 40);
      idle(10);
      check("drop_drops",   stat_drops, 1);
      check("drop_lookups", stat_lookups, 7);

      // back-to-back: requester 2 re-requests in its own req_done cycle
      resp_delay = 1;
      load(2, 12'h402, 48'h0200_0000_0042, 6'h22, 48'h0000_0000_0C01);
      exp_issue(6'h22, 12'h402, 48'h0200_0000_0042, 48'h0000_0000_0C01);
      exp_issue(6'h22, 12'h403, 48'h0200_0000_0043, 48'h0000_0000_0D00);
      exp_done(2, 1'b1, 6'h0C);
      exp_done(2, 1'b0, 6'h0D);
      pulse(4'b0100);
      n = 0;
      while (req_bus.req_done[2] !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("b2b_done_seen", req_bus.req_done[2], 1);
      load(2, 12'h403, 48'h0200_0000_0043, 6'h22, 48'h0000_0000_0D00);
      pulse(4'b0100);
      drain("b2b_drain", 30);
      check("b2b_drops",   stat_drops, 1);
      check("b2b_lookups", stat_lookups, 9);

      // timeout: table silent
      tbl_respond = 1'b0;
      load(3, 12'h503, 48'h0200_0000_0053, 6'h23, 48'h0000_0000_0901);
      exp_issue(6'h23, 12'h503, 48'h0200_0000_0053, 48'h0000_0000_0901);
      exp_done(3, 1'b0, 6'h00);
      pulse(4'b1000);
      drain("tmo_drain", 40);
      check("tmo_latency",  last_done_cyc - last_issue_cyc, TMO + 1);
      check("tmo_timeouts", stat_timeouts, 1);
      check("tmo_lookups",  stat_lookups, 10);

      // late table response while idle is ignored
      stray_cyc = cyc + 1;
      idle(6);
      check("stray_lookups",  stat_lookups, 10);
      check("stray_timeouts", stat_timeouts, 1);
      check("stray_hit_hold", req_bus.req_hit[3], 0);
      tbl_respond = 1'b1;

      // response arriving in the timeout cycle: done wins
      resp_delay = 8;
      load(1, 12'h601, 48'h0200_0000_0061, 6'h21, 48'h0000_0000_0E01);
      exp_issue(6'h21, 12'h601, 48'h0200_0000_0061, 48'h0000_0000_0E01);
      exp_done(1, 1'b1, 6'h0E);
      pulse(4'b0010);
      drain("tie_drain", 40);
      check("tie_latency",  last_done_cyc - last_issue_cyc, TMO + 1);
      check("tie_timeouts", stat_timeouts, 1);
      check("tie_lookups",  stat_lookups, 11);

      // reset while waiting on the table; slot 1 is also pending
      tbl_respond = 1'b0;
      load(0, 12'h700, 48'h0200_0000_0070, 6'h20, 48'h0000_0000_0101);
      load(1, 12'h701, 48'h0200_0000_0071, 6'h21, 48'h0000_0000_0201);
      exp_issue(6'h20, 12'h700, 48'h0200_0000_0070, 48'h0000_0000_0101);
      pulse(4'b0011);
      idle(3);
      check("rstw_issue_seen", iss_q.size(), 0);
      do_reset(1);
      idle(20);
      check("rstw_lookup_en", tbl_bus.tbl_lookup_en, 0);
      check("rstw_ready",     req_bus.req_ready, 4'hF);
      check("rstw_lookups",   stat_lookups, 0);
      tbl_respond = 1'b1;

      check("final_scoreboard", sb_q.size() + iss_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mac_lookup_arbiter.md
# mac_lookup_arbiter

Round-robin arbiter that shares the single lookup port of the fabric MAC address table among several lookup requesters (one per line-card input buffering block and uplink). Sits directly upstream of the MAC address table: captures each requester's lookup into a one-deep holding slot, issues one table lookup at a time and returns the hit/port result to the owning requester. Includes a lookup timeout and saturating drop/timeout counters so a hung table cannot stall ingress.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- TIMEOUT_CYCLES, 64: cycles to wait for table response before forcing a miss, 2..255
- clk  in  1  fabric clock
- rst  in  1  synchronous active-high reset
- req_en  in  [NUM_REQ-1:0]  one-cycle lookup request pulse per requester
- req_ready  out  [NUM_REQ-1:0]  requester slot empty; req_en accepted only when high
- req_src_vlan  in  12 x NUM_REQ  source VLAN, sampled with req_en
- req_src_mac  in  48 x NUM_REQ  source MAC, sampled with req_en
- req_src_port  in  6 x NUM_REQ  global source port, sampled with req_en
- req_dst_mac  in  48 x NUM_REQ  destination MAC, sampled with req_en
- req_done  out  [NUM_REQ-1:0]  one-cycle result pulse to owning requester
- req_hit  out  1 x NUM_REQ  result hit, valid with req_done
- req_dst_port  out  6 x NUM_REQ  result port, valid with req_done
- tbl_lookup_en  out  1  one-cycle lookup pulse to MAC table
- tbl_src_vlan / tbl_src_mac / tbl_src_port / tbl_dst_mac  out  12/48/6/48  lookup fields, held from tbl_lookup_en until result
- tbl_lookup_done  in  1  table result pulse
- tbl_lookup_hit  in  1  table hit
- tbl_lookup_dst_port  in  6  table destination port
- stat_lookups  out  32  completed lookups (incl. timeouts), wraps
- stat_drops  out  16  req_en pulses while slot full, saturates at 0xFFFF
- stat_timeouts  out  16  forced-miss completions, saturates at 0xFFFF

## Operation
- Per requester i: slot valid bit + captured fields. req_en[i] with valid[i]=0 sets valid[i] and latches fields; req_en[i] with valid[i]=1 ignored, stat_drops++.
- req_ready[i] = ~valid[i] (combinational from register).
- RR pointer ptr, reset 0. Winner = first i with valid[i], searching ptr, ptr+1, ... mod NUM_REQ.
- FSM states IDLE, WAIT.
  - IDLE: if any valid, register winner into owner, copy its fields to tbl_* outputs, pulse tbl_lookup_en, clear timer, ptr <= owner+1 mod NUM_REQ, go WAIT. Else stay.
  - WAIT: timer increments each cycle. On tbl_lookup_done: req_done[owner]=1, req_hit[owner]=tbl_lookup_hit, req_dst_port[owner]=tbl_lookup_dst_port, clear valid[owner], stat_lookups++, go IDLE. If timer reaches TIMEOUT_CYCLES without done: req_done[owner]=1, hit=0, dst_port=0, clear valid[owner], stat_lookups++, stat_timeouts++, go IDLE.
- tbl_lookup_done in IDLE (stray/late) ignored, no counter change.
- done and timeout in same cycle: done wins, no timeout count.
- Slot cleared at the edge raising req_done, so req_ready[owner] is high in the req_done cycle; req_en in that cycle is accepted.
- req_en[i] in the cycle valid[i] is being cleared: accepted (new capture), no drop.
- Non-owner req_hit/req_dst_port hold last values; only req_done qualifies them.

## Timing
- All outputs registered except req_ready. Reset: req_ready all 1, req_done 0, req_hit 0, req_dst_port 0, tbl_lookup_en 0, tbl_* fields 0, stats 0, FSM IDLE, ptr 0, all slots empty.
- req_en at cycle N (idle arbiter, empty slots): valid at N+1, tbl_lookup_en high at N+2.
- tbl_lookup_done at cycle M: req_done high at M+1; next tbl_lookup_en earliest M+2.
- Issue rate: at most one lookup per 3 cycles for a 1-cycle table response.
- Timeout: tbl_lookup_en at T, no done -> req_done at T+TIMEOUT_CYCLES+1.
- Reset mid-WAIT: aborts, no req_done emitted, pending slots discarded.

## Test plan
- Single request: req_en[0] cycle 10, table returns done at cycle 14 hit=1 port=0x05 -> tbl_lookup_en at 12, req_done[0] at 15 with hit=1 port=5, stat_lookups=1.
- Fairness: all 4 requesters pulse req_en same cycle, table responds 1 cycle after each lookup -> issue order 0,1,2,3; then requests 3 and 0 together with ptr=0 -> 0 then 3.
- Drop: req_en[1] twice while slot 1 pending -> second ignored, stat_drops=1, only one req_done[1].
- Timeout: TIMEOUT_CYCLES=8, table never responds -> req_done at tbl_lookup_en+9 with hit=0 port=0, stat_timeouts=1; late tbl_lookup_done afterwards ignored.
- Back-to-back: req_en[2] asserted in its own req_done cycle -> accepted, no drop, second lookup issued.
- Reset in WAIT: rst high 1 cycle -> all req_ready=1, tbl_lookup_en=0, stats 0, no req_done.
